// File: rtl/pool_core.sv
// 2x2 stride-2 signed max-pool engine: streams a channel-major feature map from an
// input BRAM (1-cycle latency) and writes one pooled element per window to an output BRAM.
module pool_core #(
    parameter int RD_AW = 18,
    parameter int WR_AW = 16,
    parameter int DW    = 8
) (
    input  logic             PCLK,
    input  logic             PRESETB,
    input  logic             pool_start,
    input  logic [5:0]       flen,
    input  logic [8:0]       in_channel,
    output logic             pool_done,
    output logic [31:0]      clk_counter,
    output logic             rd_en,
    output logic [RD_AW-1:0] rd_addr,
    input  logic [DW-1:0]    rd_data,
    output logic             wr_en,
    output logic [WR_AW-1:0] wr_addr,
    output logic [DW-1:0]    wr_data
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;

    logic             start_d, go, zero_n, run_end;
    logic [5:0]       flen_r;
    logic [8:0]       ch_r;
    logic [4:0]       o_r;
    logic [11:0]      fsq;
    logic [8:0]       c, c_n;
    logic [4:0]       oy, ox, oy_n, ox_n;
    logic [1:0]       e, e_n;
    logic             last_rd;
    logic [RD_AW-1:0] addr_n;
    logic             rd_vld;
    logic [1:0]       rd_e;
    logic [DW-1:0]    mx, cur_max;
    logic [WR_AW-1:0] wk;

    assign go      = (state == IDLE) && pool_start && !start_d;
    assign zero_n  = (flen < 6'd2) || (in_channel == 9'd0);
    // Last write is the only write with no read in flight behind it.
    assign run_end = wr_en && !rd_en && !rd_vld;

    always_ff @(posedge PCLK or negedge PRESETB) begin
        if (!PRESETB) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (go) state_nx = zero_n ? DONE : RUN;
            RUN:     if (run_end) state_nx = DONE;
            DONE:    if (!pool_start) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        pool_done = (state == DONE);
    end

    // Read walker: ox fastest, then oy, then channel; e selects the element within a window.
    always_comb begin
        e_n  = e + 2'd1;
        ox_n = ox;
        oy_n = oy;
        c_n  = c;
        if (e == 2'd3) begin
            ox_n = ox + 5'd1;
            if (ox == o_r - 5'd1) begin
                ox_n = '0;
                oy_n = oy + 5'd1;
                if (oy == o_r - 5'd1) begin
                    oy_n = '0;
                    c_n  = c + 9'd1;
                end
            end
        end
        last_rd = (e == 2'd3) && (ox == o_r - 5'd1) && (oy == o_r - 5'd1) && (c == ch_r - 9'd1);
        addr_n  = RD_AW'(c_n) * RD_AW'(fsq)
                + RD_AW'({oy_n, e_n[1]}) * RD_AW'(flen_r)
                + RD_AW'({ox_n, e_n[0]});
    end

    always_comb begin
        if (rd_e == 2'd0)                        cur_max = rd_data;
        else if ($signed(rd_data) > $signed(mx)) cur_max = rd_data;
        else                                     cur_max = mx;
    end

    always_ff @(posedge PCLK or negedge PRESETB) begin
        if (!PRESETB) begin
            start_d     <= 1'b0;
            flen_r      <= '0;
            ch_r        <= '0;
            o_r         <= '0;
            fsq         <= '0;
            c           <= '0;
            oy          <= '0;
            ox          <= '0;
            e           <= '0;
            rd_en       <= 1'b0;
            rd_addr     <= '0;
            rd_vld      <= 1'b0;
            rd_e        <= '0;
            mx          <= '0;
            wk          <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            clk_counter <= '0;
        end else begin
            start_d <= pool_start;
            wr_en   <= 1'b0;
            if (go) begin
                flen_r      <= flen;
                ch_r        <= in_channel;
                o_r         <= flen[5:1];
                fsq         <= 12'(flen) * 12'(flen);
                c           <= '0;
                oy          <= '0;
                ox          <= '0;
                e           <= '0;
                rd_addr     <= '0;
                rd_en       <= !zero_n;
                rd_vld      <= 1'b0;
                wk          <= '0;
                clk_counter <= '0;
            end else if (state == RUN) begin
                if (clk_counter != 32'hFFFF_FFFF) clk_counter <= clk_counter + 32'd1;
                rd_vld <= rd_en;
                rd_e   <= e;
                if (rd_en) begin
                    if (last_rd) begin
                        rd_en <= 1'b0;
                    end else begin
                        e       <= e_n;
                        ox      <= ox_n;
                        oy      <= oy_n;
                        c       <= c_n;
                        rd_addr <= addr_n;
                    end
                end
                if (rd_vld) begin
                    mx <= cur_max;
                    if (rd_e == 2'd3) begin
                        wr_en   <= 1'b1;
                        wr_data <= cur_max;
                        wr_addr <= wk;
                        wk      <= wk + WR_AW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pool_core.sv
// Randomized + directed bench for pool_core against a window-by-window max reference.
module tb_pool_core;
    localparam int RD_AW = 18;
    localparam int WR_AW = 16;
    localparam int DW    = 8;

    logic             PCLK = 0, PRESETB = 0, pool_start = 0;
    logic [5:0]       flen = 0;
    logic [8:0]       in_channel = 0;
    logic             pool_done, rd_en, wr_en;
    logic [31:0]      clk_counter;
    logic [RD_AW-1:0] rd_addr;
    logic [DW-1:0]    rd_data = 0;
    logic [WR_AW-1:0] wr_addr;
    logic [DW-1:0]    wr_data;

    pool_core #(.RD_AW(RD_AW), .WR_AW(WR_AW), .DW(DW)) dut (
        .PCLK(PCLK), .PRESETB(PRESETB), .pool_start(pool_start), .flen(flen),
        .in_channel(in_channel), .pool_done(pool_done), .clk_counter(clk_counter),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 PCLK = ~PCLK;

    logic [7:0] mem [0:4095];
    always @(posedge PCLK) if (rd_en) rd_data <= mem[rd_addr[11:0]];

    int n_chk = 0, n_pass = 0;
    int cyc = 0, t0 = 0, rd_cnt = 0, bad_rd = 0;
    int cur_f = 0, cur_ch = 0;
    typedef struct { int addr; int data; int rel; } wr_t;
    wr_t wq[$];

    always @(posedge PCLK) cyc <= cyc + 1;

    function automatic bit rd_ok(int a);
        int f2, r, y, x, o;
        f2 = cur_f * cur_f;
        if (f2 == 0) return 0;
        r = a % f2; y = r / cur_f; x = r % cur_f; o = cur_f / 2;
        return (a / f2 < cur_ch) && (y < 2 * o) && (x < 2 * o);
    endfunction

    always @(negedge PCLK) begin
        if (wr_en) wq.push_back('{int'(wr_addr), int'(wr_data), cyc - t0});
        if (rd_en) begin
            rd_cnt++;
            if (!rd_ok(int'(rd_addr))) bad_rd++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int ref_max(int f, int c, int oy, int ox);
        int m, v;
        m = -1000;
        for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++) begin
                v = int'($signed(mem[c * f * f + (2 * oy + dy) * f + 2 * ox + dx]));
                if (v > m) m = v;
            end
        return m;
    endfunction

    task automatic run(input int f, input int ch, input string tag);
        int o, n, k, done_rel, lim, exp_clk;
        @(negedge PCLK);
        flen = 6'(f); in_channel = 9'(ch); cur_f = f; cur_ch = ch;
        wq.delete(); rd_cnt = 0; bad_rd = 0; t0 = cyc; pool_start = 1;
        o = f / 2; n = o * o * ch; done_rel = -1; lim = 4 * n + 20;
        exp_clk = (n == 0) ? 0 : 4 * n + 2;
        for (int i = 0; i < lim; i++) begin
            @(negedge PCLK);
            if (pool_done) begin done_rel = cyc - t0; break; end
        end
        chk({tag, ".done_cyc"}, done_rel, (n == 0) ? 1 : 4 * n + 3);
        chk({tag, ".clk_cnt"}, clk_counter, exp_clk);
        chk({tag, ".reads"}, rd_cnt, 4 * n);
        chk({tag, ".bad_rd"}, bad_rd, 0);
        chk({tag, ".writes"}, wq.size(), n);
        k = 0;
        for (int c = 0; c < ch; c++)
            for (int oy = 0; oy < o; oy++)
                for (int ox = 0; ox < o; ox++) begin
                    if (k < wq.size()) begin
                        chk({tag, ".wr_addr"}, wq[k].addr, k);
                        chk({tag, ".wr_data"}, wq[k].data, ref_max(f, c, oy, ox) & 255);
                        chk({tag, ".wr_cyc"}, wq[k].rel, 4 * k + 6);
                    end
                    k++;
                end
        repeat (4) @(negedge PCLK);
        chk({tag, ".hold_done"}, pool_done, 1);
        chk({tag, ".hold_noact"}, rd_cnt + wq.size(), 4 * n + n);
        chk({tag, ".hold_clk"}, clk_counter, exp_clk);
        pool_start = 0;
        @(negedge PCLK);
        chk({tag, ".drop_done"}, pool_done, 0);
        chk({tag, ".drop_clk"}, clk_counter, exp_clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".done"}, pool_done, 0);
        chk({tag, ".clk"}, clk_counter, 0);
        chk({tag, ".en"}, {rd_en, wr_en}, 0);
        chk({tag, ".rd_addr"}, rd_addr, 0);
        chk({tag, ".wr_addr"}, wr_addr, 0);
        chk({tag, ".wr_data"}, wr_data, 0);
    endtask

    initial begin
        logic [7:0] rot [0:3];
        int f, ch, snap;
        rot[0] = 8'h80; rot[1] = 8'hFF; rot[2] = 8'hF9; rot[3] = 8'hFE;
        for (int i = 0; i < 4096; i++) mem[i] = 8'(i);
        #12 chk_zero("rst");
        @(negedge PCLK) PRESETB = 1;

        run(4, 1, "f4");
        for (int c = 0; c < 3; c++)
            for (int i = 0; i < 4; i++) mem[c * 4 + i] = rot[(i + c) % 4];
        run(2, 3, "f2c3");
        for (int i = 0; i < 25; i++) mem[i] = 8'(i);
        run(5, 1, "f5");
        run(0, 3, "z_flen0");
        run(4, 0, "z_ch0");
        run(1, 2, "z_flen1");
        run(2, 1, "rerun");

        for (int i = 0; i < 16; i++) mem[i] = 8'(i);
        @(negedge PCLK);
        flen = 4; in_channel = 1; cur_f = 4; cur_ch = 1; t0 = cyc; pool_start = 1;
        repeat (7) @(posedge PCLK);
        #2 PRESETB = 0;
        #1 chk_zero("midrst");
        pool_start = 0;
        snap = rd_cnt + wq.size();
        repeat (3) @(negedge PCLK);
        chk("midrst.quiet", rd_cnt + wq.size(), snap);
        chk("midrst.done", pool_done, 0);
        PRESETB = 1;
        run(4, 1, "after_rst");

        for (int r = 0; r < 8; r++) begin
            f = $urandom_range(0, 12);
            ch = $urandom_range(0, 4);
            for (int i = 0; i < f * f * ch; i++) mem[i] = 8'($urandom);
            run(f, ch, $sformatf("rnd%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/pool_core.md
Name: pool_core

Overview:
- 2x2, stride-2, signed int8 max-pool engine.
- Sits directly downstream of the pool APB register block, which supplies pool_start, flen and in_channel.
- Returns pool_done and clk_counter to that register block for CPU readback.
- Streams elements from an input feature-map BRAM (1-cycle read latency) and writes pooled results to an output BRAM.

Parameters:
- RD_AW, 18, input BRAM address width (256 ch x 32 x 32 max).
- WR_AW, 16, output BRAM address width (256 ch x 16 x 16 max).
- DW, 8, element width (signed two's complement).

Ports:
- PCLK  in  1  clock
- PRESETB  in  1  asynchronous active-low reset
- pool_start  in  1  level start from register block
- flen  in  6  input feature-map side length
- in_channel  in  9  channel count
- pool_done  out  1  completion flag
- clk_counter  out  32  busy-cycle count of last run
- rd_en  out  1  input BRAM read enable
- rd_addr  out  RD_AW  input BRAM address
- rd_data  in  DW  input BRAM data, valid the cycle after rd_en
- wr_en  out  1  output BRAM write strobe
- wr_addr  out  WR_AW  output BRAM address
- wr_data  out  DW  pooled value

Behaviour:
- Clock is PCLK; reset is PRESETB, asynchronous, active-low.
- Reset forces every output and internal register to 0: pool_done, clk_counter, rd_en, rd_addr, wr_en, wr_addr, wr_data; FSM returns to IDLE.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN: on rising edge of pool_start (registered previous value 0, current 1).
  - flen and in_channel are latched at this point; later changes are ignored until the next run.
  - clk_counter is cleared to 0.
- Geometry:
  - O = flen>>1 (odd flen: last row and column dropped).
  - N = O*O*in_channel windows.
  - If N==0: go straight to DONE the next cycle, with no reads, no writes, clk_counter=0.
- Address layout is channel-major:
  - Input: rd_addr = c*flen*flen + y*flen + x.
  - Output: wr_addr = c*O*O + oy*O + ox.
- Window order: ox fastest, then oy, then c.
- Element order within a window: (2oy,2ox), (2oy,2ox+1), (2oy+1,2ox), (2oy+1,2ox+1).
- Timing (cycle 1 = first cycle in RUN):
  - One read per cycle, rd_en high on cycles 1..4N, with no bubbles.
  - Running max is initialised from window read 0 and updated with signed compare on each returned rd_data.
  - Window k (k from 0): 4th read on cycle 4k+4, data on 4k+5.
  - Write on cycle 4k+6: wr_en=1, wr_addr=k, wr_data = signed max of the 4 elements.
  - Ties take either value (identical). wr_en is a single-cycle pulse per window.
  - Last write on cycle 4N+2; RUN -> DONE at the end of that cycle.
- clk_counter increments on every RUN cycle and equals 4N+2 in DONE. Saturates at 0xFFFFFFFF (never wraps).
- DONE:
  - pool_done=1; clk_counter, rd_addr and wr_addr are held; rd_en=wr_en=0.
  - When pool_start is sampled 0: pool_done clears and FSM returns to IDLE on the next edge. clk_counter holds until the next start.
- pool_start held high after DONE does not restart; a 0->1 edge is required.
- pool_start deasserted during RUN: ignored, the run completes.
- Reset mid-RUN: immediate abort, no further reads or writes, pool_done stays 0.
- The running max never uses data from a previous window; a new window always reloads from its first element.

Test Plan:
- flen=4, in_channel=1, input BRAM = 0..15 -> 4 writes: addr0=5, addr1=7, addr2=13, addr3=15; wr_en on cycles 6, 10, 14, 18; pool_done from cycle 19; clk_counter=18.
- flen=2, in_channel=3, channel c holds {-128,-1,-7,-2} rotated per channel -> writes addr0..2 all = -1 (0xFF), confirming signed compare; clk_counter=14.
- flen=5, in_channel=1, input BRAM = 0..24 -> row 4 and column 4 are never read; writes 6, 8, 16, 18 at addr 0..3.
- flen=0 or in_channel=0 -> pool_done 1 cycle after start, no rd_en/wr_en, clk_counter=0.
- Hold pool_start=1 after done -> no second run. Drop it -> pool_done=0 next cycle. Re-raise with flen=2, in_channel=1 -> new run, clk_counter=6.
- Assert PRESETB=0 on cycle 7 of a flen=4 run -> all outputs 0 asynchronously; after release, FSM is in IDLE and a fresh start performs a complete run.
